// File: rtl/run_step_ctrl.sv
// Run/step controller: turns filtered key pulses into the processor clock-enable,
// counts retired instructions and aborts a step that never completes.
module run_step_ctrl #(
  parameter int CNT_W        = 16,
  parameter int STEP_TIMEOUT = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             StepPulse,
  input  logic             RunPulse,
  input  logic             StopPulse,
  input  logic             InstrDone,
  input  logic             Halt,
  output logic             ProcEn,
  output logic             Running,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] InstrCount,
  output logic             Timeout
);

  localparam int TIMER_W = (STEP_TIMEOUT > 2) ? $clog2(STEP_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t             state, stateNext;
  logic               stopPending, stopPendingNext;
  logic [TIMER_W-1:0] timer, timerNext;
  logic [CNT_W-1:0]   count, countNext;
  logic               timeoutFlag, timeoutNext;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      stopPending <= 1'b0;
      timer       <= '0;
      count       <= '0;
      timeoutFlag <= 1'b0;
    end else begin
      state       <= stateNext;
      stopPending <= stopPendingNext;
      timer       <= timerNext;
      count       <= countNext;
      timeoutFlag <= timeoutNext;
    end
  end

  always_comb begin
    stateNext       = state;
    stopPendingNext = stopPending;
    timerNext       = timer;
    countNext       = count;
    timeoutNext     = timeoutFlag;

    case (state)
      IDLE: begin
        if (Halt) begin
          stateNext = HALTED;
        end else if (RunPulse || StepPulse) begin
          stateNext       = RunPulse ? RUN : STEP;
          timeoutNext     = 1'b0;
          timerNext       = '0;
          stopPendingNext = 1'b0;
        end
      end

      STEP: begin
        timerNext = timer + 1'b1;
        if (InstrDone) countNext = count + 1'b1;
        // Halt wins over both the done and the timeout exits
        if (Halt) begin
          stateNext = HALTED;
        end else if (InstrDone) begin
          stateNext = IDLE;
        end else if (timer == TIMER_W'(STEP_TIMEOUT - 1)) begin
          stateNext   = IDLE;
          timeoutNext = 1'b1;
        end
      end

      RUN: begin
        if (InstrDone) countNext = count + 1'b1;
        // Stop beats a simultaneous Run; a later Run cancels a pending stop
        if (StopPulse) stopPendingNext = 1'b1;
        else if (RunPulse) stopPendingNext = 1'b0;
        if (Halt) begin
          stateNext = HALTED;
        end else if (InstrDone && stopPending) begin
          stateNext       = IDLE;
          stopPendingNext = 1'b0;
        end
      end

      default: ;
    endcase
  end

  assign State      = state;
  assign ProcEn     = (state == STEP) || (state == RUN);
  assign Running    = (state == RUN);
  assign InstrCount = count;
  assign Timeout    = timeoutFlag;

endmodule

// File: tb/tb_run_step_ctrl.sv
// Directed self-checking bench for run_step_ctrl (4-bit counter to exercise wrap).
module tb_run_step_ctrl;

  localparam int CNT_W = 4;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             StepPulse, RunPulse, StopPulse, InstrDone, Halt;
  logic             ProcEn, Running, Timeout;
  logic [1:0]       State;
  logic [CNT_W-1:0] InstrCount;

  int assertCount = 0;
  int failCount   = 0;

  run_step_ctrl #(.CNT_W(CNT_W), .STEP_TIMEOUT(64)) dut (
    .Clk(Clk), .Reset(Reset),
    .StepPulse(StepPulse), .RunPulse(RunPulse), .StopPulse(StopPulse),
    .InstrDone(InstrDone), .Halt(Halt),
    .ProcEn(ProcEn), .Running(Running), .State(State),
    .InstrCount(InstrCount), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it
  task automatic applyStimulus(input logic step, input logic run, input logic stop,
                               input logic done, input logic halt);
    StepPulse = step; RunPulse = run; StopPulse = stop; InstrDone = done; Halt = halt;
    @(posedge Clk);
    #1;
    StepPulse = 0; RunPulse = 0; StopPulse = 0; InstrDone = 0; Halt = 0;
  endtask

  task automatic checkAll(input string tag, input logic [1:0] st, input logic en,
                          input logic [CNT_W-1:0] cnt, input logic to);
    checkOutput({tag, ".State"},   32'(State), 32'(st));
    checkOutput({tag, ".ProcEn"},  32'(ProcEn), 32'(en));
    checkOutput({tag, ".Running"}, 32'(Running), 32'(st == 2'd2));
    checkOutput({tag, ".Count"},   32'(InstrCount), 32'(cnt));
    checkOutput({tag, ".Timeout"}, 32'(Timeout), 32'(to));
  endtask

  task automatic doReset;
    Reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    Reset = 1'b0;
  endtask

  initial begin
    StepPulse = 0; RunPulse = 0; StopPulse = 0; InstrDone = 0; Halt = 0;
    doReset();
    checkAll("reset", 2'd0, 0, 0, 0);

    // Single step, InstrDone on the 4th enabled cycle
    applyStimulus(0, 0, 1, 0, 0);
    checkAll("stopInIdle", 2'd0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("step.en%0d", i), 32'(ProcEn), 32'd1);
      applyStimulus(0, 0, 0, i == 4, 0);
    end
    checkAll("stepDone", 2'd0, 0, 1, 0);

    // Run with a 3-cycle instruction, stop requested mid-instruction
    applyStimulus(0, 1, 0, 0, 0);
    checkAll("runStart", 2'd2, 1, 1, 0);
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 3; c++)
        applyStimulus(0, 0, 0, c == 2, 0);
    checkAll("run2Instr", 2'd2, 1, 3, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkAll("stopPending", 2'd2, 1, 3, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkAll("stopAtDone", 2'd0, 0, 4, 0);

    // Run cancels a pending stop; Stop+Run together leaves the stop pending
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkAll("stopCancelled", 2'd2, 1, 5, 0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkAll("stopRunTogether", 2'd0, 0, 6, 0);

    // Step timeout after 64 cycles without InstrDone
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 63; i++) applyStimulus(0, 0, 0, 0, 0);
    checkAll("timeoutEdge63", 2'd1, 1, 6, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkAll("timeoutHit", 2'd0, 0, 6, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkAll("timeoutCleared", 2'd1, 1, 6, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkAll("stepAfterTimeout", 2'd0, 0, 7, 0);

    // Step+Run together picks Run; 10 more retirements take the 4-bit count 17 -> 1
    applyStimulus(1, 1, 0, 0, 0);
    checkAll("runWins", 2'd2, 1, 7, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1, 0);
    checkAll("countWrap", 2'd2, 1, 1, 0);

    // Reset mid-run drops ProcEn without a clock edge
    #2;
    Reset = 1'b1;
    #1;
    checkAll("asyncReset", 2'd0, 0, 0, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Halt with InstrDone in RUN: count still retires, then HALTED is sticky
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkAll("haltInRun", 2'd3, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0);
    checkAll("haltSticky", 2'd3, 0, 1, 0);
    doReset();
    checkAll("haltReset", 2'd0, 0, 0, 0);

    // Halt in IDLE, and Halt during a step overriding its done exit
    applyStimulus(0, 0, 0, 0, 1);
    checkAll("haltInIdle", 2'd3, 0, 0, 0);
    doReset();
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkAll("haltInStep", 2'd3, 0, 1, 0);

    // InstrDone while disabled is never counted
    doReset();
    applyStimulus(0, 0, 0, 1, 0);
    checkAll("doneWhileIdle", 2'd0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
